demux_stream: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking. It routes one input word to one selected output channel (unicast) or to all channels (broadcast), and holds one word per channel in an output register. Each channel's `poData` holds the last delivered word after consumption. It replaces the combinational 4-way demultiplexer in datapaths that need back-pressure and N ≠ 4. It sits between a single producer and N independent consumers.

---
 rtl/stream_pkg.sv | 18 +
 rtl/demux_chan_reg.sv | 44 ++++
 rtl/demux_stream.sv | 83 ++++++++
 tb/tb_demux_stream.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared constants and elaboration helpers for the stream blocks.
package stream_pkg;

    localparam int MAX_CH = 16;

    // Smallest width that can index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register for a single demux channel.
// A load wins over a drain on the same edge; the data field keeps the last loaded word.
module demux_chan_reg #(
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with unicast/broadcast routing and
// valid/ready back-pressure on every channel.
module demux_stream
    import stream_pkg::*;
#(
    parameter int  DATA_W = 4,
    parameter int  N_CH   = 4,
    localparam int SEL_W  = clog2(N_CH)
) (
    input  logic                   piClk,
    input  logic                   piRst_n,
    input  logic [DATA_W-1:0]      piData,
    input  logic [SEL_W-1:0]       piSel,
    input  logic                   piBcast,
    input  logic                   piValid,
    output logic                   poReady,
    output logic [N_CH*DATA_W-1:0] poData,
    output logic [N_CH-1:0]        poValid,
    input  logic [N_CH-1:0]        piReady,
    output logic                   poErr
);

    logic [N_CH-1:0] selHit;
    logic [N_CH-1:0] canTake;
    logic [N_CH-1:0] loadVec;
    logic            inRange;
    logic            readyRaw;
    logic            accept;
    logic            err_q;
    logic            err_d;

    always_comb begin
        selHit = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (piSel == SEL_W'(k)) begin
                selHit[k] = 1'b1;
            end
        end
    end

    assign inRange = |selHit;
    assign canTake = ~poValid | piReady;

    // Out-of-range unicasts are always swallowed so the producer never deadlocks.
    always_comb begin
        readyRaw = 1'b1;
        if (piBcast) begin
            readyRaw = &canTake;
        end else if (inRange) begin
            readyRaw = |(selHit & canTake);
        end
    end

    assign poReady = piRst_n & readyRaw;
    assign accept  = piValid & poReady;
    assign loadVec = accept ? (piBcast ? {N_CH{1'b1}} : selHit) : '0;
    assign err_d   = accept & ~piBcast & ~inRange;

    always_ff @(posedge piClk or negedge piRst_n) begin
        if (!piRst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign poErr = err_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        demux_chan_reg #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk_i   (piClk),
            .rst_ni  (piRst_n),
            .load_i  (loadVec[k]),
            .data_i  (piData),
            .ready_i (piReady[k]),
            .valid_o (poValid[k]),
            .data_o  (poData[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// Directed checks on a 3-channel instance plus a randomized scoreboard run
// on an 8-channel, 8-bit instance.
module tb_demux_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        aRst_n;
    logic [3:0]  aData;
    logic [1:0]  aSel;
    logic        aBcast;
    logic        aValid;
    logic        aPoReady;
    logic [11:0] aPoData;
    logic [2:0]  aPoValid;
    logic [2:0]  aReady;
    logic        aPoErr;

    logic        bRst_n;
    logic [7:0]  bData;
    logic [2:0]  bSel;
    logic        bBcast;
    logic        bValid;
    logic        bPoReady;
    logic [63:0] bPoData;
    logic [7:0]  bPoValid;
    logic [7:0]  bReady;
    logic        bPoErr;

    demux_stream #(.DATA_W(4), .N_CH(3)) dutA (
        .piClk   (clk),
        .piRst_n (aRst_n),
        .piData  (aData),
        .piSel   (aSel),
        .piBcast (aBcast),
        .piValid (aValid),
        .poReady (aPoReady),
        .poData  (aPoData),
        .poValid (aPoValid),
        .piReady (aReady),
        .poErr   (aPoErr)
    );

    demux_stream #(.DATA_W(8), .N_CH(8)) dutB (
        .piClk   (clk),
        .piRst_n (bRst_n),
        .piData  (bData),
        .piSel   (bSel),
        .piBcast (bBcast),
        .piValid (bValid),
        .poReady (bPoReady),
        .poData  (bPoData),
        .poValid (bPoValid),
        .piReady (bReady),
        .poErr   (bPoErr)
    );

    logic [7:0] expQ [8][$];
    bit         monOn      = 1'b0;
    bit         randReady  = 1'b0;
    int         pushed     = 0;
    int         delivered  = 0;
    logic [7:0] mCanTake;
    logic       mExpReady;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one word to dutB and, on the accepting edge, records where it must appear.
    task automatic applyStimulus(input logic [7:0] data, input logic [2:0] sel, input logic bcast);
        bit acc;
        int waitCycles;
        bData  = data;
        bSel   = sel;
        bBcast = bcast;
        bValid = 1'b1;
        acc        = 1'b0;
        waitCycles = 0;
        while (!acc && waitCycles < 200) begin
            @(negedge clk);
            acc = bPoReady;
            @(posedge clk);
            if (acc) begin
                for (int k = 0; k < 8; k++) begin
                    if (bcast || sel == 3'(k)) begin
                        expQ[k].push_back(data);
                        pushed++;
                    end
                end
            end
            waitCycles++;
            #1;
        end
        bValid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got no accept after %0d cycles, want accept", waitCycles);
        end
    endtask

    initial begin : readyDriver
        forever begin
            @(posedge clk);
            #1;
            if (randReady) bReady = 8'($urandom);
        end
    end

    // Model: a channel holds a word exactly while its expected queue is non-empty.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (monOn) begin
                for (int k = 0; k < 8; k++) begin
                    checkOutput($sformatf("chValid%0d", k), 32'(bPoValid[k]),
                                32'(expQ[k].size() != 0));
                    mCanTake[k] = (expQ[k].size() == 0) || bReady[k];
                end
                mExpReady = bBcast ? (&mCanTake) : mCanTake[bSel];
                checkOutput("poReady", 32'(bPoReady), 32'(mExpReady));
                checkOutput("poErrB", 32'(bPoErr), 32'd0);
                for (int k = 0; k < 8; k++) begin
                    if (bPoValid[k] && bReady[k]) begin
                        if (expQ[k].size() == 0) begin
                            total++;
                            bad++;
                            $display("[TB] FAIL spurious_ch%0d: got word 0x%0h, want none", k, bPoData[k*8 +: 8]);
                        end else begin
                            checkOutput($sformatf("chData%0d", k), 32'(bPoData[k*8 +: 8]),
                                        32'(expQ[k].pop_front()));
                            delivered++;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got no finish by 400000, want finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int waitCycles;
        int remaining;
        aRst_n = 1'b0; aData = '0; aSel = '0; aBcast = 1'b0; aValid = 1'b0; aReady = 3'b111;
        bRst_n = 1'b0; bData = '0; bSel = '0; bBcast = 1'b0; bValid = 1'b0; bReady = '0;

        repeat (2) tick();
        checkOutput("rstReady", 32'(aPoReady), 32'd0);
        checkOutput("rstValid", 32'(aPoValid), 32'd0);
        checkOutput("rstData", 32'(aPoData), 32'd0);
        checkOutput("rstErr", 32'(aPoErr), 32'd0);
        aSel = 2'd3;
        aRst_n = 1'b1;
        #1;
        checkOutput("relReadyOor", 32'(aPoReady), 32'd1);
        aSel = 2'd1;
        #1;
        checkOutput("relReady", 32'(aPoReady), 32'd1);

        aData = 4'hA; aSel = 2'd2; aValid = 1'b1;
        tick(); aValid = 1'b0;
        checkOutput("uniValid1", 32'(aPoValid), 32'b100);
        checkOutput("uniData1", 32'(aPoData), 32'h A00);
        aData = 4'h5; aSel = 2'd0; aValid = 1'b1;
        tick(); aValid = 1'b0;
        checkOutput("uniValid2", 32'(aPoValid), 32'b001);
        checkOutput("uniData2", 32'(aPoData), 32'h A05);
        tick();
        checkOutput("uniValid3", 32'(aPoValid), 32'b000);
        checkOutput("uniHold", 32'(aPoData), 32'h A05);

        aReady = 3'b101;
        aData = 4'h3; aSel = 2'd1; aValid = 1'b1;
        tick();
        checkOutput("bpValid1", 32'(aPoValid), 32'b010);
        aData = 4'h7;
        #1;
        checkOutput("bpStall", 32'(aPoReady), 32'd0);
        tick();
        checkOutput("bpData1", 32'(aPoData), 32'h A35);
        aReady = 3'b111;
        #1;
        checkOutput("bpRelease", 32'(aPoReady), 32'd1);
        tick(); aValid = 1'b0;
        checkOutput("bpValid2", 32'(aPoValid), 32'b010);
        checkOutput("bpData2", 32'(aPoData), 32'h A75);
        tick();
        checkOutput("bpValid3", 32'(aPoValid), 32'b000);

        aReady = 3'b011;
        aData = 4'h6; aSel = 2'd2; aValid = 1'b1;
        tick();
        checkOutput("bcFill", 32'(aPoValid), 32'b100);
        aData = 4'hF; aBcast = 1'b1; aSel = 2'd1;
        #1;
        checkOutput("bcStall", 32'(aPoReady), 32'd0);
        tick();
        checkOutput("bcNoChangeV", 32'(aPoValid), 32'b100);
        checkOutput("bcNoChangeD", 32'(aPoData), 32'h 675);
        aReady = 3'b111;
        #1;
        checkOutput("bcRelease", 32'(aPoReady), 32'd1);
        tick(); aValid = 1'b0; aBcast = 1'b0;
        checkOutput("bcValid", 32'(aPoValid), 32'b111);
        checkOutput("bcData", 32'(aPoData), 32'h FFF);
        checkOutput("bcErr", 32'(aPoErr), 32'd0);
        tick();
        checkOutput("bcDrained", 32'(aPoValid), 32'b000);

        aData = 4'h9; aSel = 2'd3; aValid = 1'b1;
        #1;
        checkOutput("oorReady", 32'(aPoReady), 32'd1);
        tick(); aValid = 1'b0;
        checkOutput("oorErr", 32'(aPoErr), 32'd1);
        checkOutput("oorValid", 32'(aPoValid), 32'b000);
        checkOutput("oorData", 32'(aPoData), 32'h FFF);
        tick();
        checkOutput("oorErrOff", 32'(aPoErr), 32'd0);

        aReady = 3'b000;
        aData = 4'h2; aSel = 2'd0; aValid = 1'b1;
        tick(); aValid = 1'b0;
        checkOutput("midValid", 32'(aPoValid), 32'b001);
        checkOutput("midData", 32'(aPoData), 32'h FF2);
        aRst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(aPoValid), 32'd0);
        checkOutput("midRstData", 32'(aPoData), 32'd0);
        checkOutput("midRstReady", 32'(aPoReady), 32'd0);
        tick();
        aRst_n = 1'b1;
        #1;
        checkOutput("midRelReady", 32'(aPoReady), 32'd1);

        checkOutput("bRstReady", 32'(bPoReady), 32'd0);
        checkOutput("bRstValid", 32'(bPoValid), 32'd0);
        bRst_n = 1'b1;
        tick();
        randReady = 1'b1;
        monOn = 1'b1;
        for (int i = 0; i < 72; i++) begin
            applyStimulus(8'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 8) == 0));
            if ($urandom_range(0, 3) == 0) tick();
        end

        randReady = 1'b0;
        tick();
        #1;
        bReady = 8'hFF;
        waitCycles = 0;
        remaining = 1;
        while (remaining != 0 && waitCycles < 50) begin
            tick();
            remaining = 0;
            for (int k = 0; k < 8; k++) remaining += expQ[k].size();
            waitCycles++;
        end
        tick();
        checkOutput("drainLeft", 32'(remaining), 32'd0);
        checkOutput("deliveredAll", 32'(delivered), 32'(pushed));
        checkOutput("drainValid", 32'(bPoValid), 32'd0);
        monOn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
